// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// The FSM state type, the BCD digit width and the double-dabble adjust
// constants live here so the top and the digit adjuster agree on them.
package bin2bcd_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int DIGIT_W    = 4;
    localparam int ADJ_THRESH = 5;
    localparam int ADJ_VAL    = 3;

    // Largest value representable in 'digits' decimal digits (10^digits - 1).
    function automatic logic [63:0] max_decimal(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_adj_digit.sv
// One double-dabble digit adjuster: a BCD digit of 5 or more gets 3 added
// (modulo 16) so that the following left shift carries correctly into the
// next decimal digit. Purely combinational.
module bcd_adj_digit
    import bin2bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adjusted
);

    // Add-3-if-at-least-5; the 4-bit add wraps naturally.
    always_comb begin
        adjusted = digit;
        if (digit >= DIGIT_W'(ADJ_THRESH)) begin
            adjusted = digit + DIGIT_W'(ADJ_VAL);
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift-and-adjust
// iteration per clock; a conversion takes exactly WIDTH cycles from the
// accepting start edge to the done pulse.
// Optional feature: define BIN2BCD_SAT_EN to clamp results that do not fit
// in DIGITS decimal digits to all nines; otherwise the high digits are
// simply truncated.
//
// Handshake: start is only looked at in IDLE; the edge that sees start=1
// in IDLE captures bin and raises busy. busy stays high for the whole
// conversion, and done pulses for one cycle on the edge that loads bcd.
// start seen in the done cycle begins the next conversion with no gap.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [WIDTH-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*DIGITS-1:0]     bcd,
    output state_t                  dbg_state
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CAT_W = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               last_iter;
    logic [WIDTH-1:0]   shreg;
    logic [BCD_W-1:0]   work;
    logic [BCD_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt;
    logic [CAT_W-1:0]   cat_next;
    logic [BCD_W-1:0]   result;

    // One adjuster per working digit; all digits adjust in parallel.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_adj_digit u_adj (
            .digit    (work[g*DIGIT_W +: DIGIT_W]),
            .adjusted (adj[g*DIGIT_W +: DIGIT_W])
        );
    end

`ifdef BIN2BCD_SAT_EN
    localparam logic [63:0] MAX_VAL = max_decimal(DIGITS);

    logic sat_flag;

    // Decide on capture whether the operand overflows the decimal range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (accept) begin
            sat_flag <= (64'(bin) > MAX_VAL);
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the accept / final-iteration strobes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_iter  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                if (cnt == CNT_W'(1)) begin
                    last_iter  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Adjusted digits followed by the operand, shifted left by one; the
    // digit field of the shifted value is also the candidate result.
    always_comb begin
        cat_next = {adj, shreg} << 1;
        result   = cat_next[CAT_W-1:WIDTH];
`ifdef BIN2BCD_SAT_EN
        if (sat_flag) begin
            result = {DIGITS{4'h9}};
        end
`endif
    end

    // Datapath: capture, iterate, and publish the result with a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            work  <= '0;
            cnt   <= '0;
            bcd   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                shreg <= bin;
                work  <= '0;
                cnt   <= CNT_W'(WIDTH);
            end else if (state == CONV) begin
                work  <= cat_next[CAT_W-1:WIDTH];
                shreg <= cat_next[WIDTH-1:0];
                cnt   <= cnt - CNT_W'(1);
            end
            if (last_iter) begin
                bcd  <= result;
                done <= 1'b1;
            end
        end
    end

    assign busy      = (state == CONV);
    assign dbg_state = state;

endmodule
